fetch_redirect_ctrl: RTL and testbench

Front-end fetch sequencer between the redirect sources (CP0 exception, branch-misprediction flush, BTB prediction) and the I-Cache request port. Every cycle it selects the next fetch PC by fixed priority and holds a redirect that the cache has not yet accepted. It tracks accepted-but-unanswered requests and tags a fetch epoch, so responses belonging to a flushed path are marked for dropping. It feeds the PC register stage and the instruction queue.

---
 rtl/fetch_redirect_ctrl.sv | 136 +++++++++++++
 tb/tb_fetch_redirect_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC sequencer: picks the next fetch PC from redirect/BTB sources, holds unaccepted
// redirects, and tracks outstanding I-Cache requests plus stale responses from flushed paths.
module fetch_redirect_ctrl #(
  parameter logic [31:0] START_PC        = 32'hBFC0_0000,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned EPOCH_W         = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               exc_valid_i,
  input  logic [31:0]        exc_pc_i,
  input  logic               bra_valid_i,
  input  logic [31:0]        bra_pc_i,
  input  logic [31:0]        btb_pc_i,
  input  logic               btb_delay_i,
  input  logic               stop_fetch_i,
  input  logic               cache_index_ok_i,
  input  logic               cache_data_ok_i,
  output logic               req_o,
  output logic [31:0]        req_pc_o,
  output logic               req_delay_o,
  output logic               req_redirect_o,
  output logic [EPOCH_W-1:0] epoch_o,
  output logic               drop_o,
  output logic [2:0]         outstanding_o
);

  localparam logic [2:0] MaxOut = 3'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {StBoot, StRun, StHold} state_e;

  state_e             state_q, state_d;
  logic               pend_valid_q, pend_valid_d;
  logic               pend_exc_q, pend_exc_d;
  logic [31:0]        pend_pc_q, pend_pc_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic [2:0]         outstanding_q, outstanding_d;
  logic [2:0]         stale_q, stale_d;

  logic redirect_new;
  logic accept;
  logic data_ok_eff;

  assign redirect_new = exc_valid_i | bra_valid_i;
  assign accept       = req_o & cache_index_ok_i;
  // data_ok with nothing outstanding is a protocol error and is ignored
  assign data_ok_eff  = cache_data_ok_i & (outstanding_q != 3'd0);

  always_ff @(posedge clk) begin
    if (!rst) state_q <= StBoot;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StBoot: begin
        if (accept)            state_d = StRun;
        else if (redirect_new) state_d = StHold;
      end
      StRun:  if (redirect_new && !accept) state_d = StHold;
      StHold: if (accept) state_d = StRun;
      default: state_d = StBoot;
    endcase
  end

  always_comb begin
    req_o          = rst & ~stop_fetch_i & (outstanding_q < MaxOut);
    req_pc_o       = btb_pc_i;
    req_delay_o    = 1'b0;
    req_redirect_o = 1'b1;
    if (exc_valid_i) begin
      req_pc_o = exc_pc_i;
    end else if (pend_valid_q && pend_exc_q) begin
      req_pc_o = pend_pc_q;
    end else if (bra_valid_i) begin
      req_pc_o = bra_pc_i;
    end else if (pend_valid_q) begin
      req_pc_o = pend_pc_q;
    end else if (state_q == StBoot) begin
      req_pc_o = START_PC;
    end else begin
      req_delay_o    = btb_delay_i;
      req_redirect_o = 1'b0;
    end
    epoch_o       = epoch_q;
    outstanding_o = outstanding_q;
    drop_o        = cache_data_ok_i & (stale_q != 3'd0);
  end

  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_exc_d   = pend_exc_q;
    pend_pc_d    = pend_pc_q;
    if (exc_valid_i) begin
      pend_valid_d = 1'b1;
      pend_exc_d   = 1'b1;
      pend_pc_d    = exc_pc_i;
    end else if (bra_valid_i && !(pend_valid_q && pend_exc_q)) begin
      pend_valid_d = 1'b1;
      pend_exc_d   = 1'b0;
      pend_pc_d    = bra_pc_i;
    end
    if (accept && (redirect_new || pend_valid_q)) pend_valid_d = 1'b0;

    epoch_d = redirect_new ? epoch_q + EPOCH_W'(1) : epoch_q;
    outstanding_d = outstanding_q + 3'(accept) - 3'(data_ok_eff);

    // The request accepted alongside a redirect belongs to the new path, so it is not counted
    stale_d = stale_q;
    if (redirect_new) begin
      stale_d = outstanding_q - 3'(data_ok_eff);
    end else if (data_ok_eff && stale_q != 3'd0) begin
      stale_d = stale_q - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_valid_q  <= 1'b0;
      pend_exc_q    <= 1'b0;
      pend_pc_q     <= 32'd0;
      epoch_q       <= '0;
      outstanding_q <= 3'd0;
      stale_q       <= 3'd0;
    end else begin
      pend_valid_q  <= pend_valid_d;
      pend_exc_q    <= pend_exc_d;
      pend_pc_q     <= pend_pc_d;
      epoch_q       <= epoch_d;
      outstanding_q <= outstanding_d;
      stale_q       <= stale_d;
    end
  end

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed bench for fetch_redirect_ctrl: per-cycle vector table plus a back-to-back redirect run.
module tb_fetch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        exc_valid_i, bra_valid_i, btb_delay_i, stop_fetch_i;
  logic        cache_index_ok_i, cache_data_ok_i;
  logic [31:0] exc_pc_i, bra_pc_i, btb_pc_i;
  logic        req_o, req_delay_o, req_redirect_o, drop_o;
  logic [31:0] req_pc_o;
  logic [1:0]  epoch_o;
  logic [2:0]  outstanding_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_redirect_ctrl #(
    .START_PC        (32'hBFC0_0000),
    .MAX_OUTSTANDING (2),
    .EPOCH_W         (2)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .exc_valid_i      (exc_valid_i),
    .exc_pc_i         (exc_pc_i),
    .bra_valid_i      (bra_valid_i),
    .bra_pc_i         (bra_pc_i),
    .btb_pc_i         (btb_pc_i),
    .btb_delay_i      (btb_delay_i),
    .stop_fetch_i     (stop_fetch_i),
    .cache_index_ok_i (cache_index_ok_i),
    .cache_data_ok_i  (cache_data_ok_i),
    .req_o            (req_o),
    .req_pc_o         (req_pc_o),
    .req_delay_o      (req_delay_o),
    .req_redirect_o   (req_redirect_o),
    .epoch_o          (epoch_o),
    .drop_o           (drop_o),
    .outstanding_o    (outstanding_o)
  );

  typedef struct {
    logic        rst, ev;
    logic [31:0] epc;
    logic        bv;
    logic [31:0] bpc, btb;
    logic        bd, stop, iok, dok;
    logic        req;
    logic [31:0] pc;
    logic        dly, rdr;
    logic [1:0]  ep;
    logic        drp;
    logic [2:0]  outs;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic r, input logic ev, input logic [31:0] epc, input logic bv,
                     input logic [31:0] bpc, input logic [31:0] btb, input logic bd,
                     input logic stop, input logic iok, input logic dok, input logic req,
                     input logic [31:0] pc, input logic dly, input logic rdr,
                     input logic [1:0] ep, input logic drp, input logic [2:0] outs);
    vec_t t;
    t.rst = r; t.ev = ev; t.epc = epc; t.bv = bv; t.bpc = bpc; t.btb = btb; t.bd = bd;
    t.stop = stop; t.iok = iok; t.dok = dok; t.req = req; t.pc = pc; t.dly = dly;
    t.rdr = rdr; t.ep = ep; t.drp = drp; t.outs = outs;
    tv.push_back(t);
  endtask

  // Drive one cycle's inputs after the falling edge, check outputs before the rising edge.
  task automatic apply(input vec_t t, input string name);
    logic [40:0] got, exp;
    @(negedge clk);
    rst = t.rst; exc_valid_i = t.ev; exc_pc_i = t.epc; bra_valid_i = t.bv; bra_pc_i = t.bpc;
    btb_pc_i = t.btb; btb_delay_i = t.bd; stop_fetch_i = t.stop;
    cache_index_ok_i = t.iok; cache_data_ok_i = t.dok;
    #2;
    got = {req_o, req_pc_o, req_delay_o, req_redirect_o, epoch_o, drop_o, outstanding_o};
    exp = {t.req, t.pc, t.dly, t.rdr, t.ep, t.drp, t.outs};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got req=%b pc=%h dly=%b rdr=%b ep=%0d drop=%b out=%0d, expected req=%b pc=%h dly=%b rdr=%b ep=%0d drop=%b out=%0d",
               name, req_o, req_pc_o, req_delay_o, req_redirect_o, epoch_o, drop_o,
               outstanding_o, t.req, t.pc, t.dly, t.rdr, t.ep, t.drp, t.outs);
    end
  endtask

  localparam logic [31:0] Boot = 32'hBFC0_0000;
  localparam logic [31:0] Z    = 32'h0;

  initial begin
    vec_t t;
    rst = 1'b0; exc_valid_i = 1'b0; bra_valid_i = 1'b0; btb_delay_i = 1'b0;
    stop_fetch_i = 1'b0; cache_index_ok_i = 1'b0; cache_data_ok_i = 1'b0;
    exc_pc_i = '0; bra_pc_i = '0; btb_pc_i = '0;
    repeat (2) @(posedge clk);

    //   rst ev epc           bv bpc           btb           bd st iok dok | req pc            dly rdr ep drp out
    add(0, 0, Z,            0, Z,            32'h9000_0000, 0, 0, 1, 0,   0, Boot,          0, 1, 0, 0, 0); // reset
    add(1, 0, Z,            0, Z,            32'h9000_0000, 1, 0, 1, 0,   1, Boot,          0, 1, 0, 0, 0); // boot accept
    add(1, 0, Z,            0, Z,            32'h9000_0100, 1, 0, 1, 0,   1, 32'h9000_0100, 1, 0, 0, 0, 1);
    add(1, 0, Z,            0, Z,            32'h9000_0110, 0, 0, 1, 0,   0, 32'h9000_0110, 0, 0, 0, 0, 2); // limit
    add(1, 0, Z,            0, Z,            32'h9000_0110, 0, 0, 1, 1,   0, 32'h9000_0110, 0, 0, 0, 0, 2);
    add(1, 0, Z,            0, Z,            32'h9000_0110, 0, 0, 1, 1,   1, 32'h9000_0110, 0, 0, 0, 0, 1); // acc+dok
    add(1, 0, Z,            1, 32'h8000_1000, 32'h9000_0200, 0, 0, 0, 0,   1, 32'h8000_1000, 0, 1, 0, 0, 1); // bra
    add(1, 0, Z,            0, Z,            32'h9000_0210, 0, 0, 0, 0,   1, 32'h8000_1000, 0, 1, 1, 0, 1);
    add(1, 0, Z,            0, Z,            32'h9000_0220, 0, 0, 0, 0,   1, 32'h8000_1000, 0, 1, 1, 0, 1);
    add(1, 0, Z,            0, Z,            32'h9000_0230, 0, 0, 1, 0,   1, 32'h8000_1000, 0, 1, 1, 0, 1);
    add(1, 0, Z,            0, Z,            32'h9000_0300, 0, 0, 1, 1,   0, 32'h9000_0300, 0, 0, 1, 1, 2); // stale
    add(1, 0, Z,            0, Z,            32'h9000_0300, 0, 0, 0, 1,   1, 32'h9000_0300, 0, 0, 1, 0, 1);
    add(1, 1, 32'h8000_0180, 1, 32'h8000_2000, 32'h9000_0310, 0, 0, 0, 0,   1, 32'h8000_0180, 0, 1, 1, 0, 0); // exc>bra
    add(1, 0, Z,            1, 32'h8000_3000, 32'h9000_0310, 0, 0, 0, 0,   1, 32'h8000_0180, 0, 1, 2, 0, 0);
    add(1, 0, Z,            0, Z,            32'h9000_0310, 0, 0, 1, 0,   1, 32'h8000_0180, 0, 1, 3, 0, 0);
    add(1, 0, Z,            0, Z,            32'h9000_0400, 1, 0, 1, 0,   1, 32'h9000_0400, 1, 0, 3, 0, 1);
    add(1, 0, Z,            1, 32'h8000_4000, 32'h9000_0410, 0, 0, 1, 0,   0, 32'h8000_4000, 0, 1, 3, 0, 2); // 2 out
    add(1, 0, Z,            0, Z,            32'h9000_0410, 0, 0, 1, 1,   0, 32'h8000_4000, 0, 1, 0, 1, 2);
    add(1, 0, Z,            0, Z,            32'h9000_0410, 0, 0, 1, 1,   1, 32'h8000_4000, 0, 1, 0, 1, 1);
    add(1, 0, Z,            0, Z,            32'h9000_0500, 0, 0, 0, 1,   1, 32'h9000_0500, 0, 0, 0, 0, 1); // third ok
    add(1, 1, 32'h8000_0200, 0, Z,            32'h9000_0500, 0, 1, 1, 0,   0, 32'h8000_0200, 0, 1, 0, 0, 0); // stop
    add(1, 0, Z,            0, Z,            32'h9000_0500, 0, 1, 1, 0,   0, 32'h8000_0200, 0, 1, 1, 0, 0);
    add(1, 0, Z,            0, Z,            32'h9000_0500, 0, 0, 1, 0,   1, 32'h8000_0200, 0, 1, 1, 0, 0);
    add(1, 0, Z,            1, 32'h8000_5000, 32'h9000_0600, 0, 0, 0, 1,   1, 32'h8000_5000, 0, 1, 1, 0, 1); // bra+dok
    add(1, 0, Z,            0, Z,            32'h9000_0600, 0, 0, 1, 0,   1, 32'h8000_5000, 0, 1, 2, 0, 0);
    add(1, 0, Z,            0, Z,            32'h9000_0610, 0, 0, 0, 1,   1, 32'h9000_0610, 0, 0, 2, 0, 1); // not dropped
    add(1, 0, Z,            0, Z,            32'h9000_0610, 0, 0, 0, 1,   1, 32'h9000_0610, 0, 0, 2, 0, 0); // dok at 0
    add(1, 0, Z,            0, Z,            32'h9000_0610, 0, 0, 0, 0,   1, 32'h9000_0610, 0, 0, 2, 0, 0);
    add(1, 0, Z,            1, 32'h8000_6000, 32'h9000_0700, 0, 0, 1, 0,   1, 32'h8000_6000, 0, 1, 2, 0, 0);
    add(1, 0, Z,            1, 32'h8000_7000, 32'h9000_0700, 0, 0, 0, 0,   1, 32'h8000_7000, 0, 1, 3, 0, 1);
    add(0, 0, Z,            0, Z,            32'h9000_0700, 0, 0, 1, 0,   0, 32'h8000_7000, 0, 1, 0, 0, 1); // mid reset
    add(1, 0, Z,            0, Z,            32'h9000_0700, 0, 0, 0, 1,   1, Boot,          0, 1, 0, 0, 0);
    add(1, 0, Z,            0, Z,            32'h9000_0700, 0, 0, 1, 0,   1, Boot,          0, 1, 0, 0, 0);

    foreach (tv[i]) apply(tv[i], $sformatf("vec%0d", i));

    // Back-to-back branch pulses while stalled: epoch steps every cycle, newest branch wins.
    for (int i = 0; i < 3; i++) begin
      t = tv[0];
      t.rst = 1'b1; t.bv = 1'b1; t.bpc = 32'h8000_8000 + 32'(i * 16); t.btb = 32'h9000_0800;
      t.iok = 1'b0; t.req = 1'b1; t.pc = t.bpc; t.rdr = 1'b1; t.ep = 2'(i); t.outs = 3'd1;
      apply(t, $sformatf("b2b_bra%0d", i));
    end
    t.bv = 1'b0; t.iok = 1'b1; t.pc = 32'h8000_8020; t.ep = 2'd3;
    apply(t, "b2b_accept");
    t.iok = 1'b0; t.dok = 1'b1; t.req = 1'b0; t.pc = 32'h9000_0800; t.rdr = 1'b0;
    t.drp = 1'b1; t.outs = 3'd2;
    apply(t, "b2b_stale");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
